// File: rtl/vdp_vram_arbiter_if.sv
// VRAM port, fetch addresses and CPU data-port request signals for vdp_vram_arbiter.
// master = requester/VRAM side, slave = arbiter.
interface vdp_vram_arbiter_if;
    logic        ce_pix;
    logic [8:0]  x;
    logic        active;
    logic [13:0] bg_A;
    logic [13:0] spr_A;
    logic [13:0] vram_A;
    logic        vram_we;
    logic [7:0]  vram_wD;
    logic [7:0]  vram_D;
    logic        cpu_wr;
    logic [13:0] cpu_wA;
    logic [7:0]  cpu_wD;
    logic        cpu_wr_ready;
    logic        cpu_rd;
    logic [13:0] cpu_rA;
    logic        cpu_rd_busy;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rD;

    modport master (
        output ce_pix, x, active, bg_A, spr_A, vram_D,
               cpu_wr, cpu_wA, cpu_wD, cpu_rd, cpu_rA,
        input  vram_A, vram_we, vram_wD, cpu_wr_ready,
               cpu_rd_busy, cpu_rvalid, cpu_rD
    );

    modport slave (
        input  ce_pix, x, active, bg_A, spr_A, vram_D,
               cpu_wr, cpu_wA, cpu_wD, cpu_rd, cpu_rA,
        output vram_A, vram_we, vram_wD, cpu_wr_ready,
               cpu_rd_busy, cpu_rvalid, cpu_rD
    );
endinterface

// File: rtl/vdp_vram_arbiter.sv
// VDP VRAM port arbiter: x-fixed bg/sprite fetch plus CPU write FIFO and single reads in slots.
// Optional macro VDP_ARB_BLANK_BURST_EN makes every blanking ce_pix a CPU slot.
module vdp_vram_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [2:0]  CPU_PHASE  = 3'd5
) (
    input logic               clk_sys,
    input logic               reset_n,
    vdp_vram_arbiter_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t      state_q;
    logic        cpu_own_q;
    logic [13:0] cpu_A_q;
    logic        vram_we_q;
    logic [7:0]  vram_wD_q;
    logic        rd_busy_q;
    logic [13:0] rd_A_q;
    logic        rvalid_q;
    logic [7:0]  rD_q;

    logic [21:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          fifo_empty, fifo_full, push, pop;
    logic          phase_hit, slot;

    assign phase_hit = !bus.x[8] && (bus.x[2:0] == CPU_PHASE);
`ifdef VDP_ARB_BLANK_BURST_EN
    assign slot = bus.ce_pix && (bus.active ? phase_hit : 1'b1);
`else
    assign slot = bus.ce_pix && phase_hit;
`endif

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign pop        = (state_q == IDLE) && slot && !fifo_empty;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign push       = bus.cpu_wr && (!fifo_full || pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (push)
            fifo_mem[wr_ptr_q] <= {bus.cpu_wA, bus.cpu_wD};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cpu_own_q <= 1'b0;
            cpu_A_q   <= '0;
            vram_we_q <= 1'b0;
            vram_wD_q <= '0;
            rd_busy_q <= 1'b0;
            rd_A_q    <= '0;
            rvalid_q  <= 1'b0;
            rD_q      <= '0;
        end else begin
            vram_we_q <= 1'b0;
            rvalid_q  <= 1'b0;
            if (bus.cpu_rd && !rd_busy_q) begin
                rd_busy_q <= 1'b1;
                rd_A_q    <= bus.cpu_rA;
            end
            case (state_q)
                IDLE: begin
                    if (slot) begin
                        if (!fifo_empty) begin
                            state_q                <= WR;
                            cpu_own_q              <= 1'b1;
                            {cpu_A_q, vram_wD_q}   <= fifo_mem[rd_ptr_q];
                            vram_we_q              <= 1'b1;
                        end else if (rd_busy_q) begin
                            state_q   <= RD;
                            cpu_own_q <= 1'b1;
                            cpu_A_q   <= rd_A_q;
                        end
                    end
                end
                WR: begin
                    if (bus.ce_pix) begin
                        state_q   <= IDLE;
                        cpu_own_q <= 1'b0;
                    end
                end
                RD: begin
                    if (bus.ce_pix) begin
                        state_q   <= IDLE;
                        cpu_own_q <= 1'b0;
                        rD_q      <= bus.vram_D;
                        rvalid_q  <= 1'b1;
                        rd_busy_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.vram_A       = cpu_own_q ? cpu_A_q :
                              ((bus.x[8] && (bus.x <= 9'd495)) ? bus.spr_A : bus.bg_A);
    assign bus.vram_we      = vram_we_q;
    assign bus.vram_wD      = vram_wD_q;
    assign bus.cpu_wr_ready = !fifo_full;
    assign bus.cpu_rd_busy  = rd_busy_q;
    assign bus.cpu_rvalid   = rvalid_q;
    assign bus.cpu_rD       = rD_q;
endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Self-checking bench for vdp_vram_arbiter: scoreboard of expected VRAM writes/read data.
module tb_vdp_vram_arbiter;
    logic clk_sys = 1'b0;
    logic reset_n;

    vdp_vram_arbiter_if bus();

    vdp_vram_arbiter #(.FIFO_DEPTH(4), .CPU_PHASE(3'd5)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {logic [8:0] x; logic [13:0] a; logic [7:0] d;} wev_t;
    typedef struct packed {logic [8:0] x; logic [7:0] d;} rev_t;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [7:0]  vram_mem [16384];
    logic [8:0]  last_ce_x = '0;
    wev_t        obs_w [$];
    rev_t        obs_r [$];
    logic [21:0] exp_w [$];
    logic [7:0]  exp_r [$];

    initial forever #5 clk_sys = ~clk_sys;

    // Pixel timing and VRAM model: ce_pix every other clk, x advances after each ce_pix.
    initial begin
        bus.ce_pix = 1'b0;
        bus.x      = '0;
        bus.bg_A   = 14'h1000;
        bus.spr_A  = 14'h2000;
        bus.vram_D = '0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (bus.ce_pix)
                bus.x = bus.x + 9'd1;
            bus.ce_pix = ~bus.ce_pix;
            bus.bg_A   = 14'h1000 | {5'd0, bus.x};
            bus.spr_A  = 14'h2000 | {5'd0, bus.x};
            bus.vram_D = vram_mem[bus.vram_A];
            @(negedge clk_sys);
            if (bus.vram_we)
                vram_mem[bus.vram_A] = bus.vram_wD;
        end
    end

    always @(negedge clk_sys) begin
        if (bus.vram_we)
            obs_w.push_back({last_ce_x, bus.vram_A, bus.vram_wD});
        if (bus.cpu_rvalid)
            obs_r.push_back({last_ce_x, bus.cpu_rD});
        if (bus.ce_pix)
            last_ce_x = bus.x;
    end

    task automatic wait_x(input logic [8:0] tx);
        int n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (bus.x !== tx && n < 3000);
        if (bus.x !== tx) begin
            total_cnt++;
            $display("FAIL wait_x: x=%0d, required %0d within 3000 cycles", bus.x, tx);
        end
    endtask

    task automatic cpu_write(input logic [13:0] a, input logic [7:0] d, input bit accept);
        bus.cpu_wr = 1'b1;
        bus.cpu_wA = a;
        bus.cpu_wD = d;
        if (accept)
            exp_w.push_back({a, d});
        @(negedge clk_sys);
        bus.cpu_wr = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (5) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        total_cnt++; if (bus.cpu_wr_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", bus.cpu_wr_ready); else pass_cnt++;
        total_cnt++; if (bus.cpu_rd_busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", bus.cpu_rd_busy); else pass_cnt++;
        total_cnt++; if (bus.cpu_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b, required 0", bus.cpu_rvalid); else pass_cnt++;
        total_cnt++; if (bus.cpu_rD !== 8'h00) $display("FAIL reset_rD: got %h, required 00", bus.cpu_rD); else pass_cnt++;
        total_cnt++; if (bus.vram_we !== 1'b0) $display("FAIL reset_we: got %b, required 0", bus.vram_we); else pass_cnt++;
        total_cnt++; if (bus.vram_wD !== 8'h00) $display("FAIL reset_wD: got %h, required 00", bus.vram_wD); else pass_cnt++;
        total_cnt++; if (bus.vram_A !== (14'h1000 | {5'd0, bus.x}))
            $display("FAIL reset_vram_A: got %h, required %h", bus.vram_A, 14'h1000 | {5'd0, bus.x}); else pass_cnt++;
    endtask

    task automatic test_write_slots;
        wev_t ev;
        logic [21:0] e;
        bus.active = 1'b1;
        wait_x(9'd0);
        cpu_write(14'h0100, 8'hAA, 1'b1);
        cpu_write(14'h0101, 8'hBB, 1'b1);
        cpu_write(14'h3FFF, 8'hCC, 1'b1);
        wait_x(9'd10);
        total_cnt++; if (bus.vram_A !== 14'h100A) $display("FAIL slots_bg_mux: got %h, required 100a", bus.vram_A); else pass_cnt++;
        wait_x(9'd30);
        for (int unsigned i = 0; exp_w.size() > 0; i++) begin
            e = exp_w.pop_front();
            total_cnt++;
            if (obs_w.size() == 0) begin
                $display("FAIL slots_write%0d: got no write, required %h/%h", i, e[21:8], e[7:0]);
            end else begin
                ev = obs_w.pop_front();
                if ({ev.a, ev.d} !== e) $display("FAIL slots_write%0d: got %h/%h, required %h/%h", i, ev.a, ev.d, e[21:8], e[7:0]);
                else pass_cnt++;
                total_cnt++;
                if (ev.x !== 9'(5 + 8 * i)) $display("FAIL slots_x%0d: got x=%0d, required %0d", i, ev.x, 5 + 8 * i);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_no_grant_high_x;
        wev_t ev;
        logic [21:0] e;
        wait_x(9'd254);
        cpu_write(14'h0AAA, 8'h33, 1'b1);
        wait_x(9'd300);
        total_cnt++; if (bus.vram_A !== 14'h212C) $display("FAIL high_spr_300: got %h, required 212c", bus.vram_A); else pass_cnt++;
        wait_x(9'd495);
        total_cnt++; if (bus.vram_A !== 14'h21EF) $display("FAIL high_spr_495: got %h, required 21ef", bus.vram_A); else pass_cnt++;
        wait_x(9'd496);
        total_cnt++; if (bus.vram_A !== 14'h11F0) $display("FAIL high_bg_496: got %h, required 11f0", bus.vram_A); else pass_cnt++;
        wait_x(9'd511);
        total_cnt++; if (obs_w.size() != 0) $display("FAIL high_no_grant: got %0d writes, required 0", obs_w.size()); else pass_cnt++;
        wait_x(9'd20);
        e = exp_w.pop_front();
        total_cnt++;
        if (obs_w.size() == 0) begin
            $display("FAIL high_wrap_write: got no write, required %h/%h", e[21:8], e[7:0]);
        end else begin
            ev = obs_w.pop_front();
            if ({ev.x, ev.a, ev.d} !== {9'd5, e}) $display("FAIL high_wrap_write: got x=%0d %h/%h, required x=5 %h/%h", ev.x, ev.a, ev.d, e[21:8], e[7:0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_fifo_full;
        wev_t ev;
        logic [21:0] e;
        int n;
        wait_x(9'd260);
        for (int unsigned i = 0; i < 5; i++) begin
            total_cnt++;
            if (bus.cpu_wr_ready !== (i < 4)) $display("FAIL full_ready%0d: got %b, required %b", i, bus.cpu_wr_ready, (i < 4));
            else pass_cnt++;
            cpu_write(14'h0010 + 14'(i), 8'h40 + 8'(i), i < 4);
        end
        total_cnt++; if (bus.cpu_wr_ready !== 1'b0) $display("FAIL full_ready_after: got %b, required 0", bus.cpu_wr_ready); else pass_cnt++;
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (bus.vram_we !== 1'b1 && n < 1500);
        total_cnt++; if (bus.vram_we !== 1'b1) $display("FAIL full_first_pop: got no vram_we within 1500 cycles, required one"); else pass_cnt++;
        total_cnt++; if (bus.cpu_wr_ready !== 1'b1) $display("FAIL full_ready_pop: got %b, required 1", bus.cpu_wr_ready); else pass_cnt++;
        wait_x(9'd40);
        for (int unsigned i = 0; exp_w.size() > 0; i++) begin
            e = exp_w.pop_front();
            total_cnt++;
            if (obs_w.size() == 0) begin
                $display("FAIL full_drain%0d: got no write, required %h/%h", i, e[21:8], e[7:0]);
            end else begin
                ev = obs_w.pop_front();
                if ({ev.x, ev.a, ev.d} !== {9'(5 + 8 * i), e})
                    $display("FAIL full_drain%0d: got x=%0d %h/%h, required x=%0d %h/%h", i, ev.x, ev.a, ev.d, 5 + 8 * i, e[21:8], e[7:0]);
                else pass_cnt++;
            end
        end
        total_cnt++; if (obs_w.size() != 0) $display("FAIL full_extra: got %0d extra writes, required 0", obs_w.size()); else pass_cnt++;
    endtask

    task automatic test_read_after_write;
        wev_t ev;
        rev_t rv;
        logic [21:0] e;
        logic [7:0] er;
        wait_x(9'd0);
        cpu_write(14'h0200, 8'h5A, 1'b1);
        bus.cpu_rd = 1'b1;
        bus.cpu_rA = 14'h0200;
        exp_r.push_back(8'h5A);
        @(negedge clk_sys);
        bus.cpu_rd = 1'b0;
        total_cnt++; if (bus.cpu_rd_busy !== 1'b1) $display("FAIL raw_busy_set: got %b, required 1", bus.cpu_rd_busy); else pass_cnt++;
        wait_x(9'd30);
        e = exp_w.pop_front();
        total_cnt++;
        if (obs_w.size() != 1) begin
            $display("FAIL raw_write: got %0d writes, required 1", obs_w.size());
        end else begin
            ev = obs_w.pop_front();
            if ({ev.x, ev.a, ev.d} !== {9'd5, e}) $display("FAIL raw_write: got x=%0d %h/%h, required x=5 %h/%h", ev.x, ev.a, ev.d, e[21:8], e[7:0]);
            else pass_cnt++;
        end
        er = exp_r.pop_front();
        total_cnt++;
        if (obs_r.size() != 1) begin
            $display("FAIL raw_read: got %0d rvalid pulses, required 1", obs_r.size());
        end else begin
            rv = obs_r.pop_front();
            if ({rv.x, rv.d} !== {9'd14, er}) $display("FAIL raw_read: got x=%0d rD=%h, required x=14 rD=%h", rv.x, rv.d, er);
            else pass_cnt++;
        end
        total_cnt++; if (bus.cpu_rd_busy !== 1'b0) $display("FAIL raw_busy_clear: got %b, required 0", bus.cpu_rd_busy); else pass_cnt++;
        obs_w.delete();
        obs_r.delete();
    endtask

    task automatic test_blank;
        wev_t ev;
        logic [21:0] e;
        int prev_x;
        wait_x(9'd90);
        bus.active = 1'b0;
        wait_x(9'd100);
        for (int unsigned i = 0; i < 4; i++)
            cpu_write(14'h0300 + 14'(i), 8'h60 + 8'(i), 1'b1);
        wait_x(9'd200);
        prev_x = -1;
        for (int unsigned i = 0; exp_w.size() > 0; i++) begin
            e = exp_w.pop_front();
            total_cnt++;
            if (obs_w.size() == 0) begin
                $display("FAIL blank_write%0d: got no write, required %h/%h", i, e[21:8], e[7:0]);
            end else begin
                ev = obs_w.pop_front();
                if ({ev.a, ev.d} !== e) $display("FAIL blank_write%0d: got %h/%h, required %h/%h", i, ev.a, ev.d, e[21:8], e[7:0]);
                else pass_cnt++;
`ifdef VDP_ARB_BLANK_BURST_EN
                if (prev_x >= 0) begin
                    total_cnt++;
                    if (int'(ev.x) - prev_x != 2) $display("FAIL blank_spacing%0d: got %0d, required 2", i, int'(ev.x) - prev_x);
                    else pass_cnt++;
                end
`else
                total_cnt++;
                if (ev.x[2:0] !== 3'd5) $display("FAIL blank_phase%0d: got x=%0d, required x[2:0]=5", i, ev.x);
                else pass_cnt++;
                if (prev_x >= 0) begin
                    total_cnt++;
                    if (int'(ev.x) - prev_x != 8) $display("FAIL blank_spacing%0d: got %0d, required 8", i, int'(ev.x) - prev_x);
                    else pass_cnt++;
                end
`endif
                prev_x = int'(ev.x);
            end
        end
        bus.active = 1'b1;
    endtask

    task automatic test_reset_mid_read;
        wait_x(9'd0);
        bus.cpu_rd = 1'b1;
        bus.cpu_rA = 14'h0123;
        @(negedge clk_sys);
        bus.cpu_rd = 1'b0;
        wait_x(9'd6);
        total_cnt++; if (bus.vram_A !== 14'h0123) $display("FAIL rst_rd_granted: got %h, required 0123", bus.vram_A); else pass_cnt++;
        cpu_write(14'h0777, 8'h11, 1'b0);
        reset_n = 1'b0;
        #1;
        total_cnt++; if (bus.vram_A !== 14'h1006) $display("FAIL rst_vram_A: got %h, required 1006", bus.vram_A); else pass_cnt++;
        total_cnt++; if (bus.cpu_rd_busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", bus.cpu_rd_busy); else pass_cnt++;
        total_cnt++; if (bus.cpu_wr_ready !== 1'b1) $display("FAIL rst_ready: got %b, required 1", bus.cpu_wr_ready); else pass_cnt++;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        wait_x(9'd40);
        total_cnt++; if (obs_r.size() != 0) $display("FAIL rst_no_rvalid: got %0d pulses, required 0", obs_r.size()); else pass_cnt++;
        total_cnt++; if (obs_w.size() != 0) $display("FAIL rst_fifo_empty: got %0d writes, required 0", obs_w.size()); else pass_cnt++;
        total_cnt++; if (bus.cpu_rd_busy !== 1'b0) $display("FAIL rst_busy_after: got %b, required 0", bus.cpu_rd_busy); else pass_cnt++;
    endtask

    initial begin
        bus.active = 1'b1;
        bus.cpu_wr = 1'b0;
        bus.cpu_wA = '0;
        bus.cpu_wD = '0;
        bus.cpu_rd = 1'b0;
        bus.cpu_rA = '0;
        test_reset();
        test_write_slots();
        test_no_grant_high_x();
        test_fifo_full();
        test_read_after_write();
        test_blank();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
